// File: rtl/core_pkg.sv
// Shared core constants: datapath widths and ALU control encodings used by
// decode, the ALU and every pipeline register.
package core_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int ALUC_W = 3;

    typedef logic [ALUC_W-1:0] aluc_t;

    localparam aluc_t ALU_AND = 3'b000;
    localparam aluc_t ALU_OR  = 3'b001;
    localparam aluc_t ALU_ADD = 3'b010;
    localparam aluc_t ALU_SUB = 3'b110;
    localparam aluc_t ALU_SLT = 3'b111;

endpackage

// File: rtl/flopr_clr.sv
// Register with synchronous reset and synchronous clear; both force zero.
// Used for every field group of the pipeline registers.
module flopr_clr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: non-blocking assignment so every register samples pre-edge values;
    // reset is tested inside the clocked block, so it only acts on a rising edge.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register: loads decode fields each edge, or
// inserts an all-zero bubble on flush, and counts flush bubbles (saturating).
module id_ex_reg #(
    parameter int DATA_W = core_pkg::DATA_W,
    parameter int REG_W  = core_pkg::REG_W,
    parameter int ALUC_W = core_pkg::ALUC_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flushe,
    input  logic              valid_d,
    input  logic              reg_write_d,
    input  logic              memtoreg_d,
    input  logic              memwrite_d,
    input  logic              alusrc_d,
    input  logic              regdst_d,
    input  logic [ALUC_W-1:0] alucontrol_d,
    input  logic [DATA_W-1:0] rd1_d,
    input  logic [DATA_W-1:0] rd2_d,
    input  logic [DATA_W-1:0] signimm_d,
    input  logic [REG_W-1:0]  rs_d,
    input  logic [REG_W-1:0]  rt_d,
    input  logic [REG_W-1:0]  rd_d,
    output logic              valid_e,
    output logic              reg_write_e,
    output logic              memtoreg_e,
    output logic              memwrite_e,
    output logic              alusrc_e,
    output logic [ALUC_W-1:0] alucontrol_e,
    output logic [DATA_W-1:0] rd1_e,
    output logic [DATA_W-1:0] rd2_e,
    output logic [DATA_W-1:0] signimm_e,
    output logic [REG_W-1:0]  rs_e,
    output logic [REG_W-1:0]  rt_e,
    output logic [REG_W-1:0]  rd_e,
    output logic [REG_W-1:0]  writereg_e,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int CTRL_W = 6 + ALUC_W;
    localparam int DAT_W  = 3 * DATA_W;
    localparam int SPEC_W = 3 * REG_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              regdst_e;
    logic [CTRL_W-1:0] ctrl_d, ctrl_q;
    logic [DAT_W-1:0]  dat_d,  dat_q;
    logic [SPEC_W-1:0] spec_d, spec_q;

    assign ctrl_d = {valid_d, reg_write_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d, alucontrol_d};
    assign dat_d  = {rd1_d, rd2_d, signimm_d};
    assign spec_d = {rs_d, rt_d, rd_d};

    flopr_clr #(.WIDTH(CTRL_W)) u_ctrl (
        .clk (clk),
        .rst (rst),
        .clr (flushe),
        .d   (ctrl_d),
        .q   (ctrl_q)
    );

    flopr_clr #(.WIDTH(DAT_W)) u_data (
        .clk (clk),
        .rst (rst),
        .clr (flushe),
        .d   (dat_d),
        .q   (dat_q)
    );

    // Zeroed specifiers on a bubble keep forwarding and branch-stall logic quiet.
    flopr_clr #(.WIDTH(SPEC_W)) u_spec (
        .clk (clk),
        .rst (rst),
        .clr (flushe),
        .d   (spec_d),
        .q   (spec_q)
    );

    assign {valid_e, reg_write_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e, alucontrol_e} = ctrl_q;
    assign {rd1_e, rd2_e, signimm_e} = dat_q;
    assign {rs_e, rt_e, rd_e}        = spec_q;

    assign writereg_e = regdst_e ? rd_e : rt_e;

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (flushe && (bubble_cnt != CNT_MAX)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed steps then randomized traffic,
// compared against a slot-level reference model.
module tb_id_ex_reg;
    import core_pkg::*;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              memtoreg;
        logic              memwrite;
        logic              alusrc;
        logic              regdst;
        logic [ALUC_W-1:0] alucontrol;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] signimm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
    } slot_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  flushe;
    slot_t cur_d;

    logic              valid_e, reg_write_e, memtoreg_e, memwrite_e, alusrc_e;
    logic [ALUC_W-1:0] alucontrol_e;
    logic [DATA_W-1:0] rd1_e, rd2_e, signimm_e;
    logic [REG_W-1:0]  rs_e, rt_e, rd_e, writereg_e;
    logic [CNT_W-1:0]  bubble_cnt;

    slot_t exp_e;
    int    exp_cnt;
    int    checks   = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    id_ex_reg #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .flushe       (flushe),
        .valid_d      (cur_d.valid),
        .reg_write_d  (cur_d.reg_write),
        .memtoreg_d   (cur_d.memtoreg),
        .memwrite_d   (cur_d.memwrite),
        .alusrc_d     (cur_d.alusrc),
        .regdst_d     (cur_d.regdst),
        .alucontrol_d (cur_d.alucontrol),
        .rd1_d        (cur_d.rd1),
        .rd2_d        (cur_d.rd2),
        .signimm_d    (cur_d.signimm),
        .rs_d         (cur_d.rs),
        .rt_d         (cur_d.rt),
        .rd_d         (cur_d.rd),
        .valid_e      (valid_e),
        .reg_write_e  (reg_write_e),
        .memtoreg_e   (memtoreg_e),
        .memwrite_e   (memwrite_e),
        .alusrc_e     (alusrc_e),
        .alucontrol_e (alucontrol_e),
        .rd1_e        (rd1_e),
        .rd2_e        (rd2_e),
        .signimm_e    (signimm_e),
        .rs_e         (rs_e),
        .rt_e         (rt_e),
        .rd_e         (rd_e),
        .writereg_e   (writereg_e),
        .bubble_cnt   (bubble_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"},      32'(valid_e),      32'(exp_e.valid));
        check({tag, ".reg_write"},  32'(reg_write_e),  32'(exp_e.reg_write));
        check({tag, ".memtoreg"},   32'(memtoreg_e),   32'(exp_e.memtoreg));
        check({tag, ".memwrite"},   32'(memwrite_e),   32'(exp_e.memwrite));
        check({tag, ".alusrc"},     32'(alusrc_e),     32'(exp_e.alusrc));
        check({tag, ".alucontrol"}, 32'(alucontrol_e), 32'(exp_e.alucontrol));
        check({tag, ".rd1"},        rd1_e,             exp_e.rd1);
        check({tag, ".rd2"},        rd2_e,             exp_e.rd2);
        check({tag, ".signimm"},    signimm_e,         exp_e.signimm);
        check({tag, ".rs"},         32'(rs_e),         32'(exp_e.rs));
        check({tag, ".rt"},         32'(rt_e),         32'(exp_e.rt));
        check({tag, ".rd"},         32'(rd_e),         32'(exp_e.rd));
        check({tag, ".writereg"},   32'(writereg_e),   32'(exp_e.regdst ? exp_e.rd : exp_e.rt));
        check({tag, ".bubble_cnt"}, 32'(bubble_cnt),   32'(exp_cnt));
    endtask

    // One clock edge: update the reference from the inputs presented at that
    // edge, then compare one time unit later.
    task automatic step(input string tag);
        @(posedge clk);
        if (rst) begin
            exp_e   = '0;
            exp_cnt = 0;
        end else if (flushe) begin
            exp_e = '0;
            if (exp_cnt < CNT_MAX) exp_cnt = exp_cnt + 1;
        end else begin
            exp_e = cur_d;
        end
        #1;
        check_all(tag);
    endtask

    function automatic slot_t rand_slot();
        slot_t s;
        s.valid      = 1'($urandom());
        s.reg_write  = 1'($urandom());
        s.memtoreg   = 1'($urandom());
        s.memwrite   = 1'($urandom());
        s.alusrc     = 1'($urandom());
        s.regdst     = 1'($urandom());
        s.alucontrol = ALUC_W'($urandom());
        s.rd1        = $urandom();
        s.rd2        = $urandom();
        s.signimm    = $urandom();
        s.rs         = REG_W'($urandom());
        s.rt         = REG_W'($urandom());
        s.rd         = REG_W'($urandom());
        return s;
    endfunction

    initial begin
        exp_e   = '0;
        exp_cnt = 0;

        // Reset with every decode field non-zero
        cur_d  = '1;
        rst    = 1'b1;
        flushe = 1'b0;
        step("reset0");
        step("reset1");

        // Pass-through: R-type add writing rd
        rst    = 1'b0;
        cur_d  = '0;
        cur_d.valid      = 1'b1;
        cur_d.reg_write  = 1'b1;
        cur_d.regdst     = 1'b1;
        cur_d.alucontrol = ALU_ADD;
        cur_d.rd1        = 32'h11;
        cur_d.rd2        = 32'h22;
        cur_d.rs         = 5'd3;
        cur_d.rt         = 5'd4;
        cur_d.rd         = 5'd5;
        step("add");
        check("add.writereg_is_rd", 32'(writereg_e), 32'd5);

        // Same specifiers, load writing rt
        cur_d.regdst   = 1'b0;
        cur_d.alusrc   = 1'b1;
        cur_d.memtoreg = 1'b1;
        cur_d.signimm  = 32'hFFFF_FFFC;
        step("lw");
        check("lw.writereg_is_rt", 32'(writereg_e), 32'd4);

        // Flush a decoded load
        cur_d.rt = 5'd8;
        flushe   = 1'b1;
        step("flush");
        check("flush.memtoreg", 32'(memtoreg_e), 32'd0);
        check("flush.writereg", 32'(writereg_e), 32'd0);
        check("flush.count",    32'(bubble_cnt), 32'd1);

        // Next edge without flush loads normally
        flushe = 1'b0;
        step("after_flush");
        check("after_flush.rt", 32'(rt_e), 32'd8);

        // Reset and flush on the same edge: reset wins, counter cleared
        cur_d  = rand_slot();
        rst    = 1'b1;
        flushe = 1'b1;
        step("rst_and_flush");
        check("rst_and_flush.count", 32'(bubble_cnt), 32'd0);

        // Fetch bubble: loads, not counted
        rst    = 1'b0;
        flushe = 1'b1;
        step("pre_fetch_bubble");
        flushe      = 1'b0;
        cur_d       = rand_slot();
        cur_d.valid = 1'b0;
        step("fetch_bubble");
        check("fetch_bubble.count", 32'(bubble_cnt), 32'd1);

        // Saturation: 20 consecutive flushes on a 4-bit counter
        rst = 1'b1;
        step("sat_reset");
        rst    = 1'b0;
        flushe = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cur_d = rand_slot();
            step("saturate");
            if (i == CNT_MAX) check("sat.reach_max", 32'(bubble_cnt), 32'(CNT_MAX));
        end
        check("sat.hold_max", 32'(bubble_cnt), 32'(CNT_MAX));

        // Mid-stream reset discards the in-flight instruction
        flushe = 1'b0;
        cur_d  = rand_slot();
        step("mid_load");
        cur_d = rand_slot();
        rst   = 1'b1;
        step("mid_reset");
        rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            rst    = ($urandom_range(0, 15) == 0);
            flushe = ($urandom_range(0, 3) == 0);
            cur_d  = rand_slot();
            step("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

Decode-to-execute pipeline register for the 32-bit pipelined RISC core. It captures decode-stage control, operands, register specifiers and sign-extended immediate on every clock, and drives the execute-stage copies consumed by the ALU, the operand-forwarding muxes and the hazard unit. It consumes `flushe` from the hazard unit, inserting a bubble on a load-use or branch stall, and keeps a saturating count of inserted bubbles for performance debug.

## Interface
- `DATA_W`, 32, operand/immediate width
- `REG_W`, 5, register-specifier width
- `ALUC_W`, 3, ALU control width
- `CNT_W`, 16, bubble-counter width
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `flushe`  in  1  hazard-unit flush; load a bubble this edge
- `valid_d`  in  1  decode slot holds a real instruction
- `reg_write_d`, `memtoreg_d`, `memwrite_d`, `alusrc_d`, `regdst_d`  in  1 each  decode control
- `alucontrol_d`  in  ALUC_W  ALU operation
- `rd1_d`, `rd2_d`  in  DATA_W  register-file read data
- `signimm_d`  in  DATA_W  sign-extended immediate
- `rs_d`, `rt_d`, `rd_d`  in  REG_W  register specifiers
- `valid_e`, `reg_write_e`, `memtoreg_e`, `memwrite_e`, `alusrc_e`  out  1 each  registered control
- `alucontrol_e`  out  ALUC_W
- `rd1_e`, `rd2_e`, `signimm_e`  out  DATA_W
- `rs_e`, `rt_e`, `rd_e`  out  REG_W
- `writereg_e`  out  REG_W  destination: `rd_e` if registered regdst is 1, else `rt_e`
- `bubble_cnt`  out  CNT_W  saturating count of flush bubbles

## Operation
- Every edge, one of three actions, in priority order: `rst` -> clear; `flushe` -> clear (bubble); otherwise load all `_d` inputs.
- Clear sets every registered field to 0: controls, `valid_e`, data, immediate, specifiers, and internal `regdst_e`. Zeroing `rs_e`/`rt_e` guarantees no spurious forwarding; zeroing `writereg_e` guarantees no spurious branch stall.
- No stall/enable input. Execute never stalls; a decode stall is always paired with `flushe`.
- `writereg_e` is combinational from registered `regdst_e`, `rt_e`, `rd_e`. It is the only combinational output.
- `bubble_cnt` increments by 1 on each edge with `flushe`=1 and `rst`=0. It saturates at all-ones and holds. `rst` clears it to 0.
- `valid_d`=0 with `flushe`=0 loads normally. It is a bubble from fetch, not counted.
- No arithmetic on data fields. Widths pass straight through.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on outputs after edge N.
- Reset value of every output: 0, including `writereg_e` (regdst 0 -> `rt_e`=0) and `bubble_cnt`.
- `rst` and `flushe` high together: reset result; counter cleared, not incremented.
- `flushe` high for k consecutive edges: k bubbles, counter +k (saturating).
- Counter at max with `flushe`: stays max; no wrap.
- `rst` asserted mid-stream: the next edge discards the in-flight instruction. Decode inputs at that edge are ignored.

## Structure
- Shared package `core_pkg`: `DATA_W`, `REG_W`, `ALUC_W` constants and the ALU control encodings (`ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`). It is shared with decode, ALU and the other pipeline registers.
- Sub-module `flopr_clr` (parameter `WIDTH`; ports `clk`, `rst`, `clr`, `d`, `q`): synchronous-reset, synchronous-clear register. It is instantiated once per field group and reused by `if_id_reg`.
- Saturating counter and `writereg_e` mux are inline.

## Test plan
- Reset: `rst`=1 for 2 edges with all `_d` inputs non-zero -> all outputs 0, `bubble_cnt`=0.
- Pass-through: load add with `rs_d`=3, `rt_d`=4, `rd_d`=5, `regdst_d`=1, `reg_write_d`=1, `rd1_d`=0x11, `rd2_d`=0x22 -> next cycle identical `_e` values, `writereg_e`=5. Repeat with `regdst_d`=0 (lw) -> `writereg_e`=4.
- Flush: `flushe`=1 with lw decoded (`memtoreg_d`=1, `rt_d`=8) -> `memtoreg_e`=0, `reg_write_e`=0, `rs_e`=`rt_e`=`writereg_e`=0, `valid_e`=0, `bubble_cnt`=1. Next edge without flush loads normally.
- Priority: `rst`=1 and `flushe`=1 on same edge -> all 0, `bubble_cnt`=0.
- Saturation: force `CNT_W`=4 and flush 20 consecutive edges -> `bubble_cnt` reaches 15 on edge 15 and holds 15.
- Fetch bubble: `valid_d`=0, `flushe`=0 -> `valid_e`=0, `bubble_cnt` unchanged.
